// File: rtl/key_led_pkg.sv
// Shared encodings for the key/LED mode controller and its helpers.
package key_led_pkg;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_ON   = 2'd1;
    localparam logic [1:0] MODE_SLOW = 2'd2;
    localparam logic [1:0] MODE_FAST = 2'd3;

    typedef enum logic [1:0] {
        CLS_IDLE = 2'd0,
        CLS_WAIT = 2'd1,
        CLS_HOLD = 2'd2
    } cls_state_t;

    // Short-press mode sequence; FAST rolls back to OFF by design.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms tick generator: one-cycle registered pulse every SCLK_FREQ/1000 cycles.
module ms_tick_gen #(
    parameter int SCLK_FREQ = 50_000_000
) (
    input  logic sclk,
    input  logic nrst,
    output logic ms_tick
);

    localparam int DIV = SCLK_FREQ / 1000;
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Prescaler 0..DIV-1; the tick fires on wrap, so the first one lands on cycle DIV.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign ms_tick = r_tick;

endmodule

// File: rtl/key_led_mode_ctrl.sv
// Key-pulse classifier, LED mode sequencer and blink generator.
//
// Classifier states:
//   state    | meaning
//   CLS_IDLE | no pulse group in progress
//   CLS_WAIT | group open, counting pulses; window expiry means short press
//   CLS_HOLD | long press already reported; absorb repeats until the key is released
module key_led_mode_ctrl
    import key_led_pkg::*;
#(
    parameter int SCLK_FREQ     = 50_000_000,
    parameter int SLOW_HALF_MS  = 500,
    parameter int FAST_HALF_MS  = 100,
    parameter int REPEAT_WIN_MS = 120,
    parameter int LONG_COUNT    = 3
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       key_pulse,
    output logic       led,
    output logic [1:0] mode,
    output logic       short_evt,
    output logic       long_evt
);

    localparam int WIN_W     = $clog2(REPEAT_WIN_MS) + 1;
    localparam int REP_W     = $clog2(LONG_COUNT) + 1;
    localparam int BLINK_MAX = (SLOW_HALF_MS > FAST_HALF_MS) ? SLOW_HALF_MS : FAST_HALF_MS;
    localparam int BLK_W     = $clog2(BLINK_MAX) + 1;

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(REPEAT_WIN_MS - 1);
    localparam logic [REP_W-1:0] REP_LONG  = REP_W'(LONG_COUNT);
    localparam logic [BLK_W-1:0] SLOW_LAST = BLK_W'(SLOW_HALF_MS - 1);
    localparam logic [BLK_W-1:0] FAST_LAST = BLK_W'(FAST_HALF_MS - 1);

    logic             w_ms_tick;
    cls_state_t       r_cls, w_cls_nxt;
    logic [WIN_W-1:0] r_win, w_win_nxt;
    logic [REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc;
    logic             r_short, r_long, w_short_nxt, w_long_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic             r_led, w_led_nxt;
    logic [BLK_W-1:0] r_blink, w_blink_nxt, w_half_last;

    ms_tick_gen #(.SCLK_FREQ(SCLK_FREQ)) u_ms_tick (
        .sclk    (sclk),
        .nrst    (nrst),
        .ms_tick (w_ms_tick)
    );

    assign w_rep_inc = r_rep + REP_W'(1);

    // Classifier next state: a pulse always beats a coincident window-expiry tick.
    always_comb begin
        w_cls_nxt   = r_cls;
        w_win_nxt   = r_win;
        w_rep_nxt   = r_rep;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        case (r_cls)
            CLS_IDLE: begin
                if (key_pulse) begin
                    w_cls_nxt = CLS_WAIT;
                    w_win_nxt = '0;
                    w_rep_nxt = REP_W'(1);
                end
            end
            CLS_WAIT: begin
                if (key_pulse) begin
                    w_win_nxt = '0;
                    w_rep_nxt = w_rep_inc;
                    if (w_rep_inc == REP_LONG) begin
                        w_cls_nxt  = CLS_HOLD;
                        w_long_nxt = 1'b1;
                    end
                end else if (w_ms_tick) begin
                    if (r_win == WIN_LAST) begin
                        w_cls_nxt   = CLS_IDLE;
                        w_short_nxt = 1'b1;
                        w_win_nxt   = '0;
                        w_rep_nxt   = '0;
                    end else begin
                        w_win_nxt = r_win + WIN_W'(1);
                    end
                end
            end
            CLS_HOLD: begin
                if (key_pulse) begin
                    w_win_nxt = '0;
                end else if (w_ms_tick) begin
                    if (r_win == WIN_LAST) begin
                        w_cls_nxt = CLS_IDLE;
                        w_win_nxt = '0;
                        w_rep_nxt = '0;
                    end else begin
                        w_win_nxt = r_win + WIN_W'(1);
                    end
                end
            end
            default: begin
                w_cls_nxt = CLS_IDLE;
                w_win_nxt = '0;
                w_rep_nxt = '0;
            end
        endcase
    end

    // Mode sequencing on the same edge the strobe is registered; long wins.
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_long_nxt) begin
            w_mode_nxt = MODE_OFF;
        end else if (w_short_nxt) begin
            w_mode_nxt = next_mode(r_mode);
        end
    end

    assign w_half_last = (w_mode_nxt == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

    // LED waveform: steady in OFF/ON, blink restarts high whenever a blink mode is entered.
    always_comb begin
        w_led_nxt   = r_led;
        w_blink_nxt = r_blink;
        case (w_mode_nxt)
            MODE_OFF: begin
                w_led_nxt   = 1'b0;
                w_blink_nxt = '0;
            end
            MODE_ON: begin
                w_led_nxt   = 1'b1;
                w_blink_nxt = '0;
            end
            default: begin
                if (w_mode_nxt != r_mode) begin
                    w_led_nxt   = 1'b1;
                    w_blink_nxt = '0;
                end else if (w_ms_tick) begin
                    if (r_blink == w_half_last) begin
                        w_led_nxt   = ~r_led;
                        w_blink_nxt = '0;
                    end else begin
                        w_blink_nxt = r_blink + BLK_W'(1);
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_cls   <= CLS_IDLE;
            r_win   <= '0;
            r_rep   <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_mode  <= MODE_OFF;
            r_led   <= 1'b0;
            r_blink <= '0;
        end else begin
            r_cls   <= w_cls_nxt;
            r_win   <= w_win_nxt;
            r_rep   <= w_rep_nxt;
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            r_mode  <= w_mode_nxt;
            r_led   <= w_led_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign short_evt = r_short;
    assign long_evt  = r_long;

endmodule
